// File: rtl/rotary_input_conditioner.sv
// Rotary encoder / push-button input conditioner.
// Brings raw asynchronous pins into clk, then debounces each channel with a
// shared sample tick and per-channel saturating stability counters. Produces
// clean levels plus a one-cycle strobe coincident with every level change.
module rotary_input_conditioner #(
    parameter int WIDTH          = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] toggled,
    output logic             sample_tick
);

    localparam int TICK_W = $clog2(SAMPLE_CNT_MAX);
    localparam int STAB_W = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(PULSE_CNT_MAX - 1);

    logic [WIDTH-1:0]  r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]  w_sync;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;
    logic [STAB_W-1:0] r_stab [WIDTH];
    logic [WIDTH-1:0]  r_deb;
    logic [WIDTH-1:0]  r_tog;

    // Multi-flop synchronizer chain per channel; stage 0 is the only one
    // that may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Free-running sample-period counter, wraps after its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Tick decoded straight from the counter so it aligns with the sampling
    // edge of the stability counters below.
    assign w_tick      = (r_tick_cnt == TICK_LAST);
    assign sample_tick = w_tick;

    // Per-channel qualification: any sample that agrees with the current
    // level restarts the count, so rising and falling edges are treated
    // identically and a bounce back to the old level costs a full restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_stab[i] <= '0;
            end
            r_deb <= '0;
            r_tog <= '0;
        end else begin
            r_tog <= '0;
            if (w_tick) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_sync[i] == r_deb[i]) begin
                        r_stab[i] <= '0;
                    end else if (r_stab[i] == STAB_LAST) begin
                        r_deb[i]  <= ~r_deb[i];
                        r_tog[i]  <= 1'b1;
                        r_stab[i] <= '0;
                    end else begin
                        r_stab[i] <= r_stab[i] + STAB_W'(1);
                    end
                end
            end
        end
    end

    assign debounced = r_deb;
    assign toggled   = r_tog;

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Bench for rotary_input_conditioner: directed scenarios plus random pin
// activity, all compared cycle by cycle against a sample-window reference.
module tb_rotary_input_conditioner;

    localparam int W = 3;
    localparam int S = 2;
    localparam int M = 4;
    localparam int P = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw_in = '1;
    logic [W-1:0] debounced;
    logic [W-1:0] toggled;
    logic         sample_tick;

    always #5 clk = ~clk;

    rotary_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(S), .SAMPLE_CNT_MAX(M), .PULSE_CNT_MAX(P)
    ) u_dut (
        .clk(clk), .rst(rst), .raw_in(raw_in),
        .debounced(debounced), .toggled(toggled), .sample_tick(sample_tick)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: pins seen S edges late, sampled every M-th edge after reset
    // release; a level flips when its last P samples all disagree with it.
    int           m_edges = 0;
    logic [W-1:0] m_raw_q [$];
    logic [W-1:0] m_samp_q [$];
    logic [W-1:0] m_deb = '0;
    logic [W-1:0] m_tog = '0;
    logic [W-1:0] m_sync;
    logic         m_all_differ;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges = 0;
            m_raw_q.delete();
            m_samp_q.delete();
            m_deb = '0;
            m_tog = '0;
        end else begin
            m_sync = (m_edges >= S) ? m_raw_q[m_edges - S] : '0;
            m_raw_q.push_back(raw_in);
            m_tog = '0;
            if (m_edges % M == M - 1) begin
                m_samp_q.push_back(m_sync);
                if (m_samp_q.size() >= P) begin
                    for (int ch = 0; ch < W; ch++) begin
                        m_all_differ = 1'b1;
                        for (int k = 1; k <= P; k++)
                            if (m_samp_q[m_samp_q.size() - k][ch] == m_deb[ch]) m_all_differ = 1'b0;
                        if (m_all_differ) begin
                            m_deb[ch] = ~m_deb[ch];
                            m_tog[ch] = 1'b1;
                        end
                    end
                end
            end
            m_edges++;
        end
    end

    // Every-cycle comparison against the reference.
    always @(posedge clk) begin
        #1;
        chk("deb", debounced, m_deb);
        chk("tog", toggled, m_tog);
        chk("tick", sample_tick, (!rst && (m_edges % M == M - 1)));
    end

    // Wait for a visible tick, then slip ph more cycles; returns at a negedge.
    task automatic wait_tick(input int ph);
        int k;
        k = 0;
        @(negedge clk);
        while (!sample_tick && k < 2 * M) begin
            @(negedge clk);
            k++;
        end
        chk("tick_align", sample_tick, 1'b1);
        repeat (ph) @(negedge clk);
    endtask

    // Counts edges from now (first edge = 1) until debounced[ch] == val.
    task automatic measure(input int ch, input logic val, input string tag, output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (debounced[ch] == val) break;
        end
        chk({tag, "_lat_in_11_14"}, (lat >= 11 && lat <= 14), 1'b1);
        chk({tag, "_strobe"}, toggled[ch], 1'b1);
        @(posedge clk);
        #1;
        chk({tag, "_strobe_off"}, toggled[ch], 1'b0);
    endtask

    initial begin
        int           lat;
        logic [15:0]  tick_seen;
        logic [3:0]   glitch_seen;
        logic [1:0]   gray [4];
        logic [1:0]   prev;
        logic [1:0]   cap [$];

        gray = '{2'b01, 2'b11, 2'b10, 2'b00};

        // Reset with all pins high: outputs held at zero.
        repeat (3) @(negedge clk);
        chk("rst_deb", debounced, 3'b000);
        chk("rst_tog", toggled, 3'b000);
        chk("rst_tick", sample_tick, 1'b0);
        rst    = 1'b0;
        raw_in = '0;

        // Tick pattern in cycles 0..15 after release.
        tick_seen = '0;
        for (int c = 0; c < 16; c++) begin
            tick_seen[c] = sample_tick;
            @(negedge clk);
        end
        chk("first_ticks", tick_seen, 16'h8888);

        // Clean rising and falling steps on channel 0 at every tick phase.
        for (int ph = 0; ph < M; ph++) begin
            wait_tick(ph);
            raw_in[0] = 1'b1;
            measure(0, 1'b1, "step_rise", lat);
            wait_tick(ph);
            raw_in[0] = 1'b0;
            measure(0, 1'b0, "step_fall", lat);
        end

        // Five-cycle pulses on channel 1 never get through.
        for (int ph = 0; ph < M; ph++) begin
            wait_tick(ph);
            glitch_seen = '0;
            raw_in[1] = 1'b1;
            repeat (5) begin
                @(negedge clk);
                glitch_seen = glitch_seen | {debounced[1], toggled};
            end
            raw_in[1] = 1'b0;
            repeat (20) begin
                @(negedge clk);
                glitch_seen = glitch_seen | {debounced[1], toggled};
            end
            chk("glitch", glitch_seen, 4'b0000);
        end

        // Bounce on channel 2: the low dip is sampled and qualification restarts.
        for (int ph = 0; ph < 2; ph++) begin
            wait_tick(ph);
            raw_in[2] = 1'b1;
            repeat (9) @(negedge clk);
            raw_in[2] = 1'b0;
            repeat (2) @(negedge clk);
            chk("bounce_still_low", debounced[2], 1'b0);
            raw_in[2] = 1'b1;
            measure(2, 1'b1, "bounce", lat);
            @(negedge clk);
            raw_in[2] = 1'b0;
            repeat (20) @(negedge clk);
        end

        // Quadrature Gray walk on A/B.
        prev = debounced[1:0];
        chk("quad_start", prev, 2'b00);
        for (int st = 0; st < 4; st++) begin
            raw_in[1:0] = gray[st];
            repeat (20) begin
                @(negedge clk);
                if (debounced[1:0] != prev) begin
                    chk("quad_one_bit", $countones(debounced[1:0] ^ prev), 1);
                    cap.push_back(debounced[1:0]);
                    prev = debounced[1:0];
                end
            end
        end
        chk("quad_count", cap.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap.size()) chk("quad_state", cap[i], gray[i]);
        end

        // Reset while channel 0 holds two of three agreeing samples.
        wait_tick(0);
        raw_in[0] = 1'b1;
        repeat (9) @(negedge clk);
        chk("midrst_pre", debounced[0], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_during", debounced, 3'b000);
        rst = 1'b0;
        measure(0, 1'b1, "midrst", lat);
        chk("midrst_exact", lat, 12);

        // Random pin activity with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int ch = 0; ch < W; ch++)
                if ($urandom_range(0, 9) == 0) raw_in[ch] = ~raw_in[ch];
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/rotary_input_conditioner.md
# rotary_input_conditioner

Upstream front end for the rotary encoder path. It takes the raw, asynchronous encoder and push-button pins and synchronizes each one into `clk`. Each channel is then debounced with a shared sample-tick counter and per-channel saturating stability counters. The block produces clean levels and one-cycle change strobes: its `debounced[1:0]` outputs drive the decoder's `rotary_A`/`rotary_B` inputs directly, and the remaining channels go to button logic.

## Interface
- `WIDTH`, default 3: number of independent channels (bit 0 = A, bit 1 = B, bit 2 = push button).
- `SYNC_STAGES`, default 2: flip-flops in each synchronizer chain; legal values ≥2.
- `SAMPLE_CNT_MAX`, default 25000: `clk` cycles per sample tick; legal values ≥2.
- `PULSE_CNT_MAX`, default 16: consecutive disagreeing samples needed to flip an output; legal values ≥1.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `raw_in`, input, WIDTH: unsynchronized pins.
- `debounced`, output, WIDTH: clean registered levels.
- `toggled`, output, WIDTH: one-cycle strobe on each bit whose `debounced` value changed this cycle.
- `sample_tick`, output, 1: exported sample strobe, used for debug and verification.

## Operation
- **Synchronizer.** Each bit passes through a `SYNC_STAGES` flip-flop chain. `sync[i]` is the last stage.
- **Tick generator.**
  - The counter `tick_cnt` has width `$clog2(SAMPLE_CNT_MAX)` and counts 0 to SAMPLE_CNT_MAX-1, then wraps to 0.
  - `sample_tick` = (`tick_cnt` == SAMPLE_CNT_MAX-1). It is combinational from the register and is high for exactly 1 of every SAMPLE_CNT_MAX cycles.
- **Per-channel stability counter.** `stab_cnt[i]` has width `$clog2(PULSE_CNT_MAX+1)`. It updates only on a clock edge where `sample_tick`=1:
  - If `sync[i]` == `debounced[i]`: `stab_cnt[i]` ← 0.
  - Else if `stab_cnt[i]` == PULSE_CNT_MAX-1: `debounced[i]` ← ~`debounced[i]` and `stab_cnt[i]` ← 0.
  - Else: `stab_cnt[i]` ← `stab_cnt[i]`+1.
  - The counter never exceeds PULSE_CNT_MAX-1. There is no wrap.
- **Symmetric debounce.** Rising and falling edges need the same stability. Quadrature decoding depends on both levels being accurate.
- **`toggled` strobe.** `toggled[i]` is registered. It is 1 in exactly the cycle in which `debounced[i]` first shows its new value, and 0 otherwise.
- **Channel independence.** Channels are fully independent. Simultaneous changes on several bits each follow their own counters. A and B may flip on the same edge.
- **Reset** clears everything, asynchronously:
  - All sync flip-flops, `tick_cnt`, `stab_cnt`, `debounced` and `toggled` go to 0.
  - `sample_tick` is therefore 0, unless SAMPLE_CNT_MAX-1 == 0, which is illegal.
  - Reset asserted mid-count discards all partial counts. After release the tick phase restarts from 0.

## Timing
- **First tick.** The first `sample_tick` after reset release is in cycle SAMPLE_CNT_MAX-1, counting the first cycle after release as cycle 0.
- **Latency for a clean step on `raw_in[i]`** (set up before edge e0; `debounced[i]` changes after edge eN):
  - Minimum N = SYNC_STAGES + (PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX + 1.
  - Maximum N = SYNC_STAGES + PULSE_CNT_MAX·SAMPLE_CNT_MAX.
- **Glitch rejection.** A pulse lasting fewer than (PULSE_CNT_MAX-1)·SAMPLE_CNT_MAX+1 cycles must never change `debounced`.
- **Bounce.** A bounce that is sampled back at the old value restarts qualification from zero.
- **Strobe alignment.** `toggled` is coincident with the change of `debounced`. It is never asserted for 2 consecutive cycles on the same bit.

## Test plan
All scenarios use `SYNC_STAGES`=2, `SAMPLE_CNT_MAX`=4, `PULSE_CNT_MAX`=3 and `WIDTH`=3.
- **Reset values.** Assert `rst` with `raw_in`=3'b111 → all outputs are 0 during reset. After release, `sample_tick` first pulses in cycle 3 and then every 4 cycles.
- **Clean step.** Step `raw_in[0]` 0→1 and hold, sweeping all 4 tick phases → `debounced[0]` rises 11–14 cycles after the step, with a single `toggled[0]` pulse in that same cycle. The falling step gives the same bounds.
- **Glitch rejection.** Drive `raw_in[1]` high for 5 cycles and then low, at every phase → `debounced[1]` stays 0 and `toggled` stays 0.
- **Bounce.** Drive `raw_in[2]` high for 9 cycles, low for 2, then high and held → the output rises no earlier than 11 cycles after the last rising edge.
- **Quadrature.** Drive A/B through a Gray sequence 00→01→11→10→00 with 20 cycles per step → `debounced[1:0]` reproduces the sequence in order with no skipped or duplicated states, and A/B never flips during a partial count.
- **Mid-count reset.** Assert `rst` for 1 cycle while `stab_cnt[0]`=2 and the input is held high → the output stays 0. Qualification restarts, and `debounced[0]` rises 11–14 cycles after reset release.
